lmi_dcache_fill: RTL and testbench

Data-cache line-fill engine on the memory side of the dcache control state machine. It accepts a line-fill or single-word uncached read request, runs the external bus request/grant handshake and collects the read beats. It returns registered per-beat DS_VAL, BurstCounter, data and RAM word index, which the controller uses to step its FILL, WPFILL, RPFILL and UCWAIT states. Fills are critical-word-first: the RAM word index wraps modulo the line, while BurstCounter counts beats in order.

---
 rtl/lmi_dcache_fill.sv | 138 +++++++++++++
 tb/tb_lmi_dcache_fill.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lmi_dcache_fill.sv
`default_nettype none
// ============================================================================
// Module   : lmi_dcache_fill
// Brief    : Dcache line-fill / uncached-read engine on the memory bus side.
// Revision : 1.0 - initial release
// ============================================================================
module lmi_dcache_fill #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  localparam int CW        = $clog2(LINE_WORDS)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FILL_REQ,
  input  logic              UC_REQ,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic              ABORT,
  output logic              BUS_REQ,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic              BUS_BURST,
  input  logic              BUS_GNT,
  input  logic              BUS_RDVAL,
  input  logic [DATA_W-1:0] BUS_RDATA,
  input  logic              BUS_ERR,
  output logic              DS_VAL,
  output logic [CW-1:0]     BurstCounter,
  output logic [CW-1:0]     RAM_WORD,
  output logic [DATA_W-1:0] FILL_DATA,
  output logic              RAM_WE,
  output logic              FILL_BUSY,
  output logic              FILL_ERR
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_REQ   = 2'd1;
  localparam logic [1:0] c_BEAT  = 2'd2;
  localparam logic [1:0] c_DRAIN = 2'd3;

  localparam logic [CW-1:0] c_LAST = CW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] c_ONE  = CW'(1);

  logic [1:0]        r_state;
  logic [ADDR_W-3:0] r_addr;
  logic              r_isFill;
  logic [CW-1:0]     r_w0;
  logic [CW-1:0]     r_beatCnt;
  logic              r_err;

  logic w_lastBeat;
  logic w_errNow;
  logic w_unusedAddrLsb;

  // Uncached reads are a single beat, so the first beat is always the last.
  assign w_lastBeat      = ~r_isFill | (r_beatCnt == c_LAST);
  assign w_errNow        = r_err | BUS_ERR;
  assign w_unusedAddrLsb = ^REQ_ADDR[1:0];

  assign BUS_REQ   = (r_state == c_REQ);
  assign BUS_ADDR  = {r_addr, 2'b00};
  assign BUS_BURST = (r_state == c_REQ) & r_isFill;
  assign FILL_BUSY = (r_state != c_IDLE);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state      <= c_IDLE;
      r_addr       <= '0;
      r_isFill     <= 1'b0;
      r_w0         <= '0;
      r_beatCnt    <= '0;
      r_err        <= 1'b0;
      DS_VAL       <= 1'b0;
      BurstCounter <= '0;
      RAM_WORD     <= '0;
      FILL_DATA    <= '0;
      RAM_WE       <= 1'b0;
      FILL_ERR     <= 1'b0;
    end else begin
      DS_VAL   <= 1'b0;
      RAM_WE   <= 1'b0;
      FILL_ERR <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (FILL_REQ || UC_REQ) begin
            r_state  <= c_REQ;
            r_addr   <= REQ_ADDR[ADDR_W-1:2];
            r_isFill <= FILL_REQ;
            r_w0     <= REQ_ADDR[CW+1:2];
            r_err    <= 1'b0;
          end
        end
        c_REQ: begin
          if (BUS_GNT) begin
            r_beatCnt <= '0;
            r_state   <= ABORT ? c_DRAIN : c_BEAT;
          end else if (ABORT) begin
            r_state <= c_IDLE;
          end
        end
        c_BEAT: begin
          if (ABORT) begin
            // An abort swallows a coincident beat; the burst must still finish.
            if (BUS_RDVAL) begin
              r_beatCnt <= r_beatCnt + c_ONE;
              r_state   <= w_lastBeat ? c_IDLE : c_DRAIN;
            end else begin
              r_state <= c_DRAIN;
            end
          end else if (BUS_RDVAL) begin
            DS_VAL       <= 1'b1;
            FILL_DATA    <= BUS_RDATA;
            BurstCounter <= r_isFill ? r_beatCnt : c_LAST;
            RAM_WORD     <= r_w0 + r_beatCnt;
            RAM_WE       <= r_isFill & ~w_errNow;
            FILL_ERR     <= w_lastBeat & w_errNow;
            r_err        <= w_errNow;
            r_beatCnt    <= r_beatCnt + c_ONE;
            if (w_lastBeat) begin
              r_state <= c_IDLE;
              r_err   <= 1'b0;
            end
          end
        end
        c_DRAIN: begin
          if (BUS_RDVAL) begin
            r_beatCnt <= r_beatCnt + c_ONE;
            if (w_lastBeat) begin
              r_state <= c_IDLE;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lmi_dcache_fill.sv
`default_nettype none
// ============================================================================
// Module   : tb_lmi_dcache_fill
// Brief    : Randomized self-checking bench for lmi_dcache_fill.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lmi_dcache_fill;

  localparam int LW     = 4;
  localparam int CW     = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              FILL_REQ, UC_REQ, ABORT;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic              BUS_REQ, BUS_BURST, BUS_GNT, BUS_RDVAL, BUS_ERR;
  logic [ADDR_W-1:0] BUS_ADDR;
  logic [DATA_W-1:0] BUS_RDATA, FILL_DATA;
  logic              DS_VAL, RAM_WE, FILL_BUSY, FILL_ERR;
  logic [CW-1:0]     BurstCounter, RAM_WORD;

  int nChecks = 0;
  int nFails  = 0;

  lmi_dcache_fill #(.LINE_WORDS(LW), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FILL_REQ(FILL_REQ), .UC_REQ(UC_REQ),
    .REQ_ADDR(REQ_ADDR), .ABORT(ABORT), .BUS_REQ(BUS_REQ), .BUS_ADDR(BUS_ADDR),
    .BUS_BURST(BUS_BURST), .BUS_GNT(BUS_GNT), .BUS_RDVAL(BUS_RDVAL),
    .BUS_RDATA(BUS_RDATA), .BUS_ERR(BUS_ERR), .DS_VAL(DS_VAL),
    .BurstCounter(BurstCounter), .RAM_WORD(RAM_WORD), .FILL_DATA(FILL_DATA),
    .RAM_WE(RAM_WE), .FILL_BUSY(FILL_BUSY), .FILL_ERR(FILL_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after the edge; outputs are read 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkVal({tag, ".DS_VAL"}, DS_VAL, 0);
    checkVal({tag, ".BUS_REQ"}, BUS_REQ, 0);
    checkVal({tag, ".BUS_BURST"}, BUS_BURST, 0);
    checkVal({tag, ".FILL_BUSY"}, FILL_BUSY, 0);
    checkVal({tag, ".RAM_WE"}, RAM_WE, 0);
    checkVal({tag, ".FILL_ERR"}, FILL_ERR, 0);
  endtask

  // abortMode: 0 none, 1 abort before grant, 2 abort with grant.
  // abortAt / errBeat: beat index or -1. gap: fixed idle cycles or -1 for random.
  task automatic runTxn(input bit isFill, input logic [ADDR_W-1:0] addr,
                        input int gntDelay, input int abortMode,
                        input int abortAt, input int errBeat, input int gap);
    int  nBeats, w0, g;
    bit  drain, errSeen, last;
    logic [DATA_W-1:0] data;
    nBeats = isFill ? LW : 1;
    w0     = int'((addr >> 2) % LW);
    FILL_REQ = isFill;
    UC_REQ   = ~isFill | ($urandom_range(0, 1) == 1);
    REQ_ADDR = addr;
    tick();
    FILL_REQ = 0; UC_REQ = 0; REQ_ADDR = $urandom;
    checkVal("req.BUS_REQ", BUS_REQ, 1);
    checkVal("req.BUS_ADDR", BUS_ADDR, {addr[ADDR_W-1:2], 2'b00});
    checkVal("req.BUS_BURST", BUS_BURST, isFill);
    checkVal("req.FILL_BUSY", FILL_BUSY, 1);
    repeat (gntDelay) begin
      tick();
      checkVal("wait.BUS_REQ", BUS_REQ, 1);
    end
    if (abortMode == 1) begin
      ABORT = 1;
      tick();
      ABORT = 0;
      checkVal("abortReq.BUS_REQ", BUS_REQ, 0);
      checkVal("abortReq.FILL_BUSY", FILL_BUSY, 0);
      return;
    end
    BUS_GNT = 1;
    ABORT   = (abortMode == 2);
    tick();
    BUS_GNT = 0; ABORT = 0;
    checkVal("gnt.BUS_REQ", BUS_REQ, 0);
    checkVal("gnt.FILL_BUSY", FILL_BUSY, 1);
    drain   = (abortMode == 2);
    errSeen = 0;
    for (int n = 0; n < nBeats; n++) begin
      if (!drain && n == abortAt) begin
        ABORT = 1;
        tick();
        ABORT = 0;
        checkVal("abort.DS_VAL", DS_VAL, 0);
        drain = 1;
      end
      g = (gap >= 0) ? gap : int'($urandom_range(0, 2));
      repeat (g) begin
        BUS_ERR = $urandom_range(0, 1);
        tick();
        checkVal("gap.DS_VAL", DS_VAL, 0);
        checkVal("gap.FILL_BUSY", FILL_BUSY, 1);
      end
      data      = $urandom;
      BUS_RDVAL = 1;
      BUS_RDATA = data;
      BUS_ERR   = (n == errBeat);
      tick();
      BUS_RDVAL = 0; BUS_ERR = 0;
      errSeen = errSeen | (n == errBeat);
      last    = (n == nBeats - 1);
      if (drain) begin
        checkVal("drain.DS_VAL", DS_VAL, 0);
        checkVal("drain.RAM_WE", RAM_WE, 0);
      end else begin
        checkVal("beat.DS_VAL", DS_VAL, 1);
        checkVal("beat.BurstCounter", BurstCounter, isFill ? n : LW - 1);
        checkVal("beat.RAM_WORD", RAM_WORD, (w0 + n) % LW);
        checkVal("beat.FILL_DATA", FILL_DATA, data);
        checkVal("beat.RAM_WE", RAM_WE, isFill && !errSeen);
        checkVal("beat.FILL_ERR", FILL_ERR, last && errSeen);
      end
      checkVal("beat.FILL_BUSY", FILL_BUSY, !last);
    end
    tick();
    checkVal("after.DS_VAL", DS_VAL, 0);
  endtask

  initial begin
    int nb;
    bit f;
    RESET_N = 0; FILL_REQ = 0; UC_REQ = 0; REQ_ADDR = '0; ABORT = 0;
    BUS_GNT = 0; BUS_RDVAL = 0; BUS_RDATA = '0; BUS_ERR = 0;
    repeat (3) tick();
    checkIdleOutputs("reset");
    checkVal("reset.BUS_ADDR", BUS_ADDR, 0);
    checkVal("reset.FILL_DATA", FILL_DATA, 0);
    checkVal("reset.BurstCounter", BurstCounter, 0);
    checkVal("reset.RAM_WORD", RAM_WORD, 0);
    RESET_N = 1;
    tick();

    runTxn(1, 32'h1000, 2, 0, -1, -1, 0);   // aligned fill
    runTxn(1, 32'h2008, 0, 0, -1, -1, 1);   // critical-word-first
    runTxn(0, 32'h3004, 1, 0, -1, -1, 0);   // uncached
    runTxn(1, 32'h4000, 0, 0, -1, 1, 0);    // bus error on beat 1
    runTxn(1, 32'h5000, 0, 0, 2, -1, 0);    // abort after beat 1
    runTxn(1, 32'h6000, 1, 1, -1, -1, 0);   // abort before grant
    runTxn(1, 32'h7004, 0, 2, -1, -1, 0);   // abort with grant

    // Reset during BEAT after two beats.
    FILL_REQ = 1; REQ_ADDR = 32'h8000;
    tick();
    FILL_REQ = 0; BUS_GNT = 1;
    tick();
    BUS_GNT = 0;
    repeat (2) begin
      BUS_RDVAL = 1; BUS_RDATA = $urandom;
      tick();
    end
    BUS_RDVAL = 0;
    checkVal("preRst.DS_VAL", DS_VAL, 1);
    RESET_N = 0;
    tick();
    RESET_N = 1;
    checkIdleOutputs("midRst");
    checkVal("midRst.BUS_ADDR", BUS_ADDR, 0);
    checkVal("midRst.FILL_DATA", FILL_DATA, 0);
    checkVal("midRst.BurstCounter", BurstCounter, 0);
    checkVal("midRst.RAM_WORD", RAM_WORD, 0);
    repeat (2) begin
      BUS_RDVAL = 1; BUS_RDATA = $urandom;
      tick();
      checkVal("postRst.DS_VAL", DS_VAL, 0);
      checkVal("postRst.FILL_BUSY", FILL_BUSY, 0);
    end
    BUS_RDVAL = 0;
    runTxn(1, 32'h900c, 0, 0, -1, -1, 0);

    for (int t = 0; t < 150; t++) begin
      int mode, ab, eb;
      f    = ($urandom_range(0, 3) != 0);
      nb   = f ? LW : 1;
      mode = int'($urandom_range(0, 9));
      mode = (mode < 2) ? mode + 1 : 0;
      ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      eb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      runTxn(f, $urandom, int'($urandom_range(0, 3)), mode, ab, eb, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
